spi_host_ctrl: RTL and testbench

SPI host controller that sequences byte transfers to the `spi_peripheral` in the ML harness. It generates `sclk` and `cs`, shifts out `pico`, samples `poci`, and frames multi-word transactions. It replaces free-running bench clocks and the PISO/SIPO shift-register pair with one handshaked block that the harness core drives word by word.

---
 rtl/spi_host_ctrl_if.sv | 29 ++
 rtl/spi_host_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_spi_host_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_host_ctrl_if.sv
// Host-side bundle for spi_host_ctrl: frame request, tx word stream, rx word stream, status.
// Latency: none, wires only.
// Backpressure: tx words move on tx_valid & tx_ready; rx words are pulsed and cannot be stalled.
interface spi_host_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic              start;
  logic [LEN_W-1:0]  nbytes;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              done;

  // Harness core side: requests frames, supplies words, consumes results.
  modport master (
    output start, nbytes, tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, busy, done
  );

  // Controller side.
  modport slave (
    input  start, nbytes, tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, busy, done
  );
endinterface

// File: rtl/spi_host_ctrl.sv
// SPI mode-0 host: frames nbytes words, shifts MSB first on pico, samples poci on sclk rise.
// Latency: word accepted at T -> rx_valid in cycle T+1+2*DATA_W*DIV; done DIV cycles after last rx_valid.
// Backpressure: tx_ready only in LOAD; a missing tx_valid stalls with cs low and sclk low indefinitely.
module spi_host_ctrl #(
  parameter int DIV    = 2,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic           clk,
  input  logic           rst_L,
  spi_host_ctrl_if.slave bus,
  output logic           sclk,
  output logic           cs,
  output logic           pico,
  input  logic           poci
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_END
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;        // half-period / END hold timer
  logic [BIT_W-1:0]  bit_q, bit_d;        // bit index within the current word
  logic [LEN_W-1:0]  words_q, words_d;    // words still to transfer in this frame
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              tx_ready_q, tx_ready_d;
  logic              rx_valid_q, rx_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sclk_q, sclk_d;
  logic              cs_q, cs_d;
  logic              pico_q, pico_d;
  logic              div_end;

  assign div_end = (cnt_q == CNT_W'(DIV - 1));

  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign sclk         = sclk_q;
  assign cs           = cs_q;
  assign pico         = pico_q;

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    words_d    = words_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    tx_ready_d = tx_ready_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    pico_d     = pico_q;

    case (state_q)
      S_IDLE: begin
        // busy drops here, which is the cycle after the done pulse.
        busy_d     = 1'b0;
        cs_d       = 1'b1;
        sclk_d     = 1'b0;
        tx_ready_d = 1'b0;
        if (bus.start && (bus.nbytes != '0)) begin
          words_d    = bus.nbytes;
          busy_d     = 1'b1;
          cs_d       = 1'b0;
          tx_ready_d = 1'b1;
          state_d    = S_LOAD;
        end
      end

      S_LOAD: begin
        sclk_d     = 1'b0;
        tx_ready_d = 1'b1;
        if (bus.tx_valid && tx_ready_q) begin
          tx_shift_d = bus.tx_data;
          pico_d     = bus.tx_data[DATA_W-1];
          bit_d      = '0;
          cnt_d      = '0;
          tx_ready_d = 1'b0;
          state_d    = S_LOW;
        end
      end

      S_LOW: begin
        if (div_end) begin
          // poci is captured on the same edge that raises sclk.
          sclk_d     = 1'b1;
          rx_shift_d = {rx_shift_q[DATA_W-2:0], poci};
          cnt_d      = '0;
          state_d    = S_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HIGH: begin
        if (div_end) begin
          sclk_d = 1'b0;
          cnt_d  = '0;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            words_d    = words_q - LEN_W'(1);
            if (words_q == LEN_W'(1)) begin
              state_d = S_END;
            end else begin
              // Ready rises together with rx_valid so a held tx_valid streams back to back.
              tx_ready_d = 1'b1;
              state_d    = S_LOAD;
            end
          end else begin
            bit_d      = bit_q + BIT_W'(1);
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            pico_d     = tx_shift_q[DATA_W-2];
            state_d    = S_LOW;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_END: begin
        sclk_d = 1'b0;
        if (div_end) begin
          cs_d    = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame without rx_valid or done.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      words_q    <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      pico_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      words_q    <= words_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      cs_q       <= cs_d;
      pico_q     <= pico_d;
    end
  end

endmodule

// File: tb/tb_spi_host_ctrl.sv
// Bench for spi_host_ctrl: a DIV=1 and a DIV=2 instance, one active at a time via sel.
// Expectations come from frame-level timing formulas and the words sent (loopback) or an echo pattern.
// Every wait is bounded; the run ends with one summary line.
module tb_spi_host_ctrl;

  logic clk = 1'b0;
  logic rst_L;
  always #5 clk = ~clk;

  bit   sel = 1'b1;        // 1: DIV=1 instance active, 0: DIV=2 instance active
  bit   echo_mode = 1'b0;  // DIV=2 instance gets the echo peripheral on poci
  logic       start_drv = 1'b0;
  logic [3:0] nbytes_drv = '0;
  logic [7:0] tx_data_drv = '0;
  logic       tx_valid_drv = 1'b0;

  spi_host_ctrl_if #(.DATA_W(8), .LEN_W(4)) bus1 ();
  spi_host_ctrl_if #(.DATA_W(8), .LEN_W(4)) bus2 ();

  logic sclk1, cs1, pico1, poci1;
  logic sclk2, cs2, pico2, poci2;

  spi_host_ctrl #(.DIV(1), .DATA_W(8), .LEN_W(4)) u_dut1 (
    .clk(clk), .rst_L(rst_L), .bus(bus1),
    .sclk(sclk1), .cs(cs1), .pico(pico1), .poci(poci1)
  );
  spi_host_ctrl #(.DIV(2), .DATA_W(8), .LEN_W(4)) u_dut2 (
    .clk(clk), .rst_L(rst_L), .bus(bus2),
    .sclk(sclk2), .cs(cs2), .pico(pico2), .poci(poci2)
  );

  assign bus1.start    = sel ? start_drv : 1'b0;
  assign bus1.nbytes   = nbytes_drv;
  assign bus1.tx_data  = tx_data_drv;
  assign bus1.tx_valid = sel ? tx_valid_drv : 1'b0;
  assign bus2.start    = sel ? 1'b0 : start_drv;
  assign bus2.nbytes   = nbytes_drv;
  assign bus2.tx_data  = tx_data_drv;
  assign bus2.tx_valid = sel ? 1'b0 : tx_valid_drv;

  logic obs_sclk, obs_cs, obs_pico, obs_tx_ready, obs_rx_valid, obs_busy, obs_done;
  logic [7:0] obs_rx_data;
  assign obs_sclk     = sel ? sclk1 : sclk2;
  assign obs_cs       = sel ? cs1 : cs2;
  assign obs_pico     = sel ? pico1 : pico2;
  assign obs_tx_ready = sel ? bus1.tx_ready : bus2.tx_ready;
  assign obs_rx_valid = sel ? bus1.rx_valid : bus2.rx_valid;
  assign obs_rx_data  = sel ? bus1.rx_data : bus2.rx_data;
  assign obs_busy     = sel ? bus1.busy : bus2.busy;
  assign obs_done     = sel ? bus1.done : bus2.done;

  // Echo peripheral: presents 8'h5A MSB first, advancing one bit on each sclk fall.
  logic [7:0] echo_pat = 8'h5A;
  int   total_falls = 0;
  logic echo_bit;
  always @(negedge obs_sclk) if (rst_L === 1'b1) total_falls++;
  assign echo_bit = echo_pat[7 - (total_falls % 8)];
  assign poci1 = pico1;
  assign poci2 = echo_mode ? echo_bit : pico2;

  int checks = 0;
  int errors = 0;

  // Event log, sampled at the falling clock edge.
  int cyc = 0;
  int hi_run = 0;
  int hi_err = 0;
  logic prev_sclk = 1'b0, prev_cs = 1'b1;
  int acc_q[$], rxc_q[$], done_q[$], start_q[$], csf_q[$], csr_q[$], rise_q[$];
  logic [7:0] rxd_q[$];

  function automatic int div_now();
    return sel ? 1 : 2;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst_L === 1'b1) begin
      if (tx_valid_drv && obs_tx_ready) acc_q.push_back(cyc);
      if (obs_rx_valid) begin
        rxd_q.push_back(obs_rx_data);
        rxc_q.push_back(cyc);
      end
      if (obs_done) done_q.push_back(cyc);
      if (start_drv) start_q.push_back(cyc);
      if (!obs_cs && prev_cs) csf_q.push_back(cyc);
      if (obs_cs && !prev_cs) csr_q.push_back(cyc);
      if (obs_sclk && !prev_sclk) rise_q.push_back(cyc);
      if (obs_sclk) hi_run++;
      else if (prev_sclk) begin
        if (hi_run != div_now()) hi_err++;
        hi_run = 0;
      end
    end else begin
      hi_run = 0;
    end
    prev_sclk = obs_sclk;
    prev_cs   = obs_cs;
  end

  logic [7:0] wr[16];
  int         gap[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_gaps();
    for (int k = 0; k < 16; k++) gap[k] = 0;
  endtask

  // Returns at the falling edge where tx_ready is seen; accept happens on the next rising edge.
  task automatic wait_ready(output bit timed_out);
    timed_out = 1'b1;
    for (int w = 0; w < 5000; w++) begin
      @(negedge clk);
      if (obs_tx_ready === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_frame(input int n, input bit repulse);
    int b_acc, b_rx, b_done, b_start, b_csf, b_csr, b_rise, b_hi;
    int stall_bad, rise_bad, d, last, w;
    bit to, t;
    logic [7:0] expw;
    b_acc = acc_q.size(); b_rx = rxc_q.size(); b_done = done_q.size();
    b_start = start_q.size(); b_csf = csf_q.size(); b_csr = csr_q.size();
    b_rise = rise_q.size(); b_hi = hi_err;
    stall_bad = 0; rise_bad = 0; to = 1'b0; d = div_now();

    nbytes_drv = n[3:0];
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (gap[k] > 0) begin
        tx_valid_drv = 1'b0;
        wait_ready(t); to |= t;
        for (int g = 0; g < gap[k]; g++) begin
          @(negedge clk);
          if (obs_sclk !== 1'b0 || obs_cs !== 1'b0 || obs_tx_ready !== 1'b1) stall_bad++;
        end
        tick();
      end
      tx_data_drv  = wr[k];
      tx_valid_drv = 1'b1;
      wait_ready(t); to |= t;
      tick();
      if (repulse && k == 0) begin
        nbytes_drv = 4'(n + 3);
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
      end
    end
    tx_valid_drv = 1'b0;

    for (w = 0; w < 5000; w++) begin
      @(negedge clk);
      if (obs_done === 1'b1) break;
    end
    if (w == 5000) to = 1'b1;
    chk("busy_in_done_cycle", obs_busy, 1);
    @(negedge clk);
    chk("busy_after_done", obs_busy, 0);
    chk("cs_after_done", obs_cs, 1);
    repeat (3) @(negedge clk);
    chk("idle_no_tx_ready", obs_tx_ready, 0);
    tick();

    chk("frame_timeout", to, 0);
    chk("rx_count", rxc_q.size() - b_rx, n);
    chk("acc_count", acc_q.size() - b_acc, n);
    chk("sclk_rises", rise_q.size() - b_rise, 8 * n);
    chk("sclk_high_width", hi_err - b_hi, 0);
    chk("done_count", done_q.size() - b_done, 1);
    chk("cs_fall_count", csf_q.size() - b_csf, 1);
    chk("stall_sclk_cs", stall_bad, 0);
    if (rxc_q.size() - b_rx == n && acc_q.size() - b_acc == n
        && rise_q.size() - b_rise == 8 * n && done_q.size() - b_done == 1
        && csf_q.size() > b_csf && csr_q.size() > b_csr && start_q.size() > b_start) begin
      for (int k = 0; k < n; k++) begin
        expw = echo_mode ? echo_pat : wr[k];
        chk("rx_data", rxd_q[b_rx + k], expw);
        chk("rx_valid_latency", rxc_q[b_rx + k] - acc_q[b_acc + k], 1 + 16 * d);
        if (k < n - 1 && gap[k + 1] == 0)
          chk("back_to_back_accept", acc_q[b_acc + k + 1], rxc_q[b_rx + k]);
        for (int i = 0; i < 8; i++)
          if (rise_q[b_rise + 8 * k + i] - acc_q[b_acc + k] != 1 + d + 2 * i * d) rise_bad++;
      end
      chk("sclk_rise_timing", rise_bad, 0);
      last = rxc_q[b_rx + n - 1];
      chk("done_after_last_rx", done_q[b_done] - last, d);
      chk("cs_fall_after_start", csf_q[b_csf] - start_q[b_start], 1);
      chk("cs_rise_with_done", csr_q[b_csr], done_q[b_done]);
    end
  endtask

  initial begin
    int bad, b_rx, b_done, b_rise, w;
    bit t;
    rst_L = 1'b1;
    #2 rst_L = 1'b0;
    clear_gaps();
    repeat (3) @(negedge clk);
    chk("reset_sclk", obs_sclk, 0);
    chk("reset_cs", obs_cs, 1);
    chk("reset_pico", obs_pico, 0);
    chk("reset_tx_ready", obs_tx_ready, 0);
    chk("reset_rx_valid", obs_rx_valid, 0);
    chk("reset_done", obs_done, 0);
    chk("reset_busy", obs_busy, 0);
    chk("reset_rx_data", obs_rx_data, 0);
    @(posedge clk);
    #3 rst_L = 1'b1;
    tick();

    // Loopback, DIV=1, single word.
    sel = 1'b1;
    wr[0] = 8'hAC;
    run_frame(1, 1'b0);

    // Echo peripheral, DIV=2.
    sel = 1'b0;
    echo_mode = 1'b1;
    wr[0] = 8'h33;
    run_frame(1, 1'b0);
    echo_mode = 1'b0;

    // Three words with a 10-cycle tx_valid gap before the second.
    wr[0] = 8'h01; wr[1] = 8'h80; wr[2] = 8'hFF;
    gap[1] = 10;
    run_frame(3, 1'b0);
    clear_gaps();

    // Zero-length request is ignored.
    nbytes_drv = 4'd0;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (obs_busy !== 1'b0 || obs_cs !== 1'b1 || obs_done !== 1'b0) bad++;
    end
    chk("nbytes0_ignored", bad, 0);
    tick();

    // Start re-pulsed mid-frame keeps the original count.
    wr[0] = 8'($urandom); wr[1] = 8'($urandom);
    run_frame(2, 1'b1);

    // Maximum frame on the DIV=1 instance, streaming.
    sel = 1'b1;
    for (int k = 0; k < 15; k++) wr[k] = 8'($urandom);
    run_frame(15, 1'b0);

    // Random frames, random gaps, alternating instances.
    for (int r = 0; r < 4; r++) begin
      int n;
      sel = r[0];
      n = $urandom_range(1, 4);
      for (int k = 0; k < 16; k++) begin
        wr[k]  = 8'($urandom);
        gap[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      end
      run_frame(n, 1'b0);
    end
    clear_gaps();

    // Reset after bit 3 of a word, then a clean frame.
    sel = 1'b0;
    b_rx = rxc_q.size(); b_done = done_q.size(); b_rise = rise_q.size();
    nbytes_drv = 4'd1;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    tx_data_drv = 8'h99;
    tx_valid_drv = 1'b1;
    wait_ready(t);
    tick();
    tx_valid_drv = 1'b0;
    for (w = 0; w < 500 && (rise_q.size() - b_rise) < 4; w++) @(negedge clk);
    chk("reset_reached_bit3", ((rise_q.size() - b_rise) >= 4) && !t, 1);
    @(negedge clk);
    #2 rst_L = 1'b0;
    #1;
    chk("abort_cs", obs_cs, 1);
    chk("abort_sclk", obs_sclk, 0);
    chk("abort_busy", obs_busy, 0);
    chk("abort_tx_ready", obs_tx_ready, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_rx_valid_in_reset", obs_rx_valid, 0);
    chk("abort_no_done_in_reset", obs_done, 0);
    @(posedge clk);
    #3 rst_L = 1'b1;
    repeat (40) tick();
    chk("abort_no_rx_valid", rxc_q.size() - b_rx, 0);
    chk("abort_no_done", done_q.size() - b_done, 0);
    wr[0] = 8'h3C;
    run_frame(1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
